// File: rtl/gf_poly_eval_seq_if.sv
// Valid/ready bundle for the GF(2^m) polynomial evaluator: job input side and result side.
interface gf_poly_eval_seq_if #(
  parameter int SYMB_WIDTH = 8,
  parameter int MAX_DEG    = 16,
  parameter int LANES      = 4,
  parameter int DEG_W      = $clog2(MAX_DEG + 1)
);
  logic                                 s_vld;
  logic                                 s_rdy;
  logic [MAX_DEG:0][SYMB_WIDTH-1:0]     s_poly;
  logic [DEG_W-1:0]                     s_deg;
  logic [LANES-1:0][SYMB_WIDTH-1:0]     s_pts;
  logic [LANES-1:0]                     s_mask;
  logic                                 m_vld;
  logic                                 m_rdy;
  logic [LANES-1:0][SYMB_WIDTH-1:0]     m_val;
  logic [LANES-1:0]                     m_zero;
  logic [LANES-1:0]                     m_mask;

  modport master (
    output s_vld, s_poly, s_deg, s_pts, s_mask, m_rdy,
    input  s_rdy, m_vld, m_val, m_zero, m_mask
  );

  modport slave (
    input  s_vld, s_poly, s_deg, s_pts, s_mask, m_rdy,
    output s_rdy, m_vld, m_val, m_zero, m_mask
  );
endinterface

// File: rtl/gf_poly_eval_seq.sv
// Multi-lane GF(2^m) polynomial evaluator: Horner's rule, one coefficient per cycle,
// one shift-and-reduce multiplier per lane, per-lane zero flag for root search.
//
// state | meaning
// IDLE  | waiting for a job, s_rdy=1
// EVAL  | one Horner step per cycle, cnt counts down to 1
// HOLD  | result registered and presented, waits for m_rdy
module gf_poly_eval_seq #(
  parameter int                  SYMB_WIDTH = 8,
  parameter logic [SYMB_WIDTH:0] PRIM_POLY  = 'h11D,
  parameter int                  MAX_DEG    = 16,
  parameter int                  LANES      = 4,
  parameter int                  DEG_W      = $clog2(MAX_DEG + 1)
) (
  input logic               aclk,
  input logic               areset,
  gf_poly_eval_seq_if.slave bus
);

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  function automatic symb_t gf_mult(symb_t a, symb_t b);
    symb_t p;
    symb_t s;
    p = '0;
    s = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ s;
      s = s[SYMB_WIDTH-1] ? ((s << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0]) : (s << 1);
    end
    return p;
  endfunction

  state_t                          state;
  logic [DEG_W-1:0]                cnt;
  logic [DEG_W-1:0]                cnt_m1;
  logic [DEG_W-1:0]                deg_in;
  logic [MAX_DEG:0][SYMB_WIDTH-1:0] poly_q;
  logic [LANES-1:0][SYMB_WIDTH-1:0] pts_q;
  logic [LANES-1:0][SYMB_WIDTH-1:0] acc;
  logic [LANES-1:0][SYMB_WIDTH-1:0] step;
  logic [LANES-1:0][SYMB_WIDTH-1:0] pub_src;
  logic [LANES-1:0]                mask_q;
  logic [LANES-1:0]                pub_mask;
  symb_t                           lead;
  symb_t                           coef;
  logic                            accept;

  logic                            m_vld_q;
  logic [LANES-1:0][SYMB_WIDTH-1:0] m_val_q;
  logic [LANES-1:0]                m_zero_q;
  logic [LANES-1:0]                m_mask_q;

  assign bus.s_rdy  = (state == IDLE) || ((state == HOLD) && bus.m_rdy);
  assign bus.m_vld  = m_vld_q;
  assign bus.m_val  = m_val_q;
  assign bus.m_zero = m_zero_q;
  assign bus.m_mask = m_mask_q;

  assign accept = bus.s_vld && bus.s_rdy;
  assign deg_in = (bus.s_deg > DEG_W'(MAX_DEG)) ? DEG_W'(MAX_DEG) : bus.s_deg;
  assign lead   = bus.s_poly[deg_in];
  assign cnt_m1 = cnt - DEG_W'(1);
  assign coef   = poly_q[cnt_m1];

  // Result source: a deg=0 job publishes its leading coefficient directly on accept.
  always_comb begin
    step     = '0;
    pub_src  = '0;
    pub_mask = accept ? bus.s_mask : mask_q;
    for (int l = 0; l < LANES; l++) begin
      step[l]    = gf_mult(acc[l], pts_q[l]) ^ coef;
      pub_src[l] = accept ? lead : step[l];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      cnt      <= '0;
      poly_q   <= '0;
      pts_q    <= '0;
      mask_q   <= '0;
      acc      <= '0;
      m_vld_q  <= 1'b0;
      m_val_q  <= '0;
      m_zero_q <= '0;
      m_mask_q <= '0;
    end else if (accept) begin
      poly_q <= bus.s_poly;
      pts_q  <= bus.s_pts;
      mask_q <= bus.s_mask;
      cnt    <= deg_in;
      for (int l = 0; l < LANES; l++) acc[l] <= lead;
      if (deg_in == '0) begin
        state    <= HOLD;
        m_vld_q  <= 1'b1;
        m_mask_q <= pub_mask;
        for (int l = 0; l < LANES; l++) begin
          m_val_q[l]  <= pub_mask[l] ? pub_src[l] : '0;
          m_zero_q[l] <= pub_mask[l] && (pub_src[l] == '0);
        end
      end else begin
        state   <= EVAL;
        m_vld_q <= 1'b0;
      end
    end else begin
      case (state)
        EVAL: begin
          acc <= step;
          cnt <= cnt_m1;
          if (cnt == DEG_W'(1)) begin
            state    <= HOLD;
            m_vld_q  <= 1'b1;
            m_mask_q <= pub_mask;
            for (int l = 0; l < LANES; l++) begin
              m_val_q[l]  <= pub_mask[l] ? pub_src[l] : '0;
              m_zero_q[l] <= pub_mask[l] && (pub_src[l] == '0);
            end
          end
        end
        HOLD: begin
          if (bus.m_rdy) begin
            state   <= IDLE;
            m_vld_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_poly_eval_seq.sv
// Randomized and directed bench for gf_poly_eval_seq; reference is a log/antilog
// sum-of-terms evaluation of the polynomial.
module tb_gf_poly_eval_seq;
  localparam int W       = 8;
  localparam int MAX_DEG = 16;
  localparam int LANES   = 4;
  localparam int DEG_W   = $clog2(MAX_DEG + 1);

  typedef logic [MAX_DEG:0][W-1:0] poly_t;
  typedef logic [LANES-1:0][W-1:0] pts_t;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  gf_poly_eval_seq_if #(.SYMB_WIDTH(W), .MAX_DEG(MAX_DEG), .LANES(LANES), .DEG_W(DEG_W)) bus ();

  gf_poly_eval_seq #(.SYMB_WIDTH(W), .PRIM_POLY(9'h11D), .MAX_DEG(MAX_DEG), .LANES(LANES),
                     .DEG_W(DEG_W)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int gexp [0:254];
  int glog [0:255];

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return 8'(gexp[(glog[a] + glog[b]) % 255]);
  endfunction

  function automatic logic [7:0] gpow(logic [7:0] x, int n);
    if (n == 0) return 8'h01;
    if (x == 0) return 8'h00;
    return 8'(gexp[(glog[x] * n) % 255]);
  endfunction

  // p(x) = XOR over i<=deg of c_i * x^i
  function automatic logic [7:0] model_eval(poly_t p, int deg, logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i <= deg; i++) r = r ^ gmul(p[i], gpow(x, i));
    return r;
  endfunction

  task automatic send(poly_t p, int deg, pts_t pts, logic [3:0] mask);
    int n;
    n = 0;
    while (!bus.s_rdy && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    check_eq("s_rdy_before_send", 64'(bus.s_rdy), 64'(1));
    bus.s_poly = p;
    bus.s_deg  = DEG_W'(deg);
    bus.s_pts  = pts;
    bus.s_mask = mask;
    bus.s_vld  = 1'b1;
    @(posedge aclk); #1;
    bus.s_vld  = 1'b0;
  endtask

  // Called one cycle after the accepting edge; m_rdy is held low by the caller.
  task automatic expect_result(string tag, poly_t p, int deg, pts_t pts, logic [3:0] mask);
    int n, d;
    pts_t ev;
    logic [3:0] ez;
    logic [7:0] v;
    d = (deg > MAX_DEG) ? MAX_DEG : deg;
    for (int l = 0; l < LANES; l++) begin
      v     = model_eval(p, d, pts[l]);
      ev[l] = mask[l] ? v : 8'h00;
      ez[l] = mask[l] && (v == 8'h00);
    end
    n = 1;
    while (!bus.m_vld && n < 60) begin
      @(posedge aclk); #1;
      n++;
    end
    check_eq({tag, "_lat"},  64'(n), 64'(d + 1));
    check_eq({tag, "_val"},  64'(bus.m_val), 64'(ev));
    check_eq({tag, "_zero"}, 64'(bus.m_zero), 64'(ez));
    check_eq({tag, "_mask"}, 64'(bus.m_mask), 64'(mask));
  endtask

  task automatic consume();
    bus.m_rdy = 1'b1;
    @(posedge aclk); #1;
    bus.m_rdy = 1'b0;
  endtask

  function automatic poly_t rand_poly();
    poly_t p;
    for (int i = 0; i <= MAX_DEG; i++) p[i] = 8'($urandom);
    return p;
  endfunction

  function automatic pts_t rand_pts();
    pts_t t;
    for (int l = 0; l < LANES; l++) t[l] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    poly_t p, p2;
    pts_t  t, t2, snap;
    logic [3:0] zsnap;
    int e, deg, stall;
    logic stable, saw_vld;

    e = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = e;
      glog[e] = i;
      e = e << 1;
      if (e & 9'h100) e = e ^ 9'h11D;
    end
    glog[0] = 0;

    areset = 1'b1;
    bus.s_vld = 1'b0; bus.s_poly = '0; bus.s_deg = '0; bus.s_pts = '0; bus.s_mask = '0;
    bus.m_rdy = 1'b0;
    #12;
    check_eq("rst_s_rdy",  64'(bus.s_rdy), 64'(1));
    check_eq("rst_m_vld",  64'(bus.m_vld), 64'(0));
    check_eq("rst_m_val",  64'(bus.m_val), 64'(0));
    check_eq("rst_m_zero", 64'(bus.m_zero), 64'(0));
    check_eq("rst_m_mask", 64'(bus.m_mask), 64'(0));
    #10 areset = 1'b0;
    @(posedge aclk); #1;

    // x^2+x+1 at 0x02
    p = '0; p[0] = 8'h01; p[1] = 8'h01; p[2] = 8'h01;
    t = rand_pts(); t[0] = 8'h02;
    send(p, 2, t, 4'b0001);
    expect_result("t1", p, 2, t, 4'b0001);
    check_eq("t1_lit", 64'(bus.m_val[0]), 64'h07);
    consume();

    // x+1 at four points
    p = '0; p[0] = 8'h01; p[1] = 8'h01;
    t[0] = 8'h01; t[1] = 8'h00; t[2] = 8'h02; t[3] = 8'h80;
    send(p, 1, t, 4'hF);
    expect_result("t2", p, 1, t, 4'hF);
    check_eq("t2_lit_val",  64'(bus.m_val), 64'h81030100);
    check_eq("t2_lit_zero", 64'(bus.m_zero), 64'h1);
    consume();

    // x^2 at 0x80 exercises reduction
    p = '0; p[2] = 8'h01;
    t = rand_pts(); t[0] = 8'h80;
    send(p, 2, t, 4'b0001);
    expect_result("t3", p, 2, t, 4'b0001);
    check_eq("t3_lit", 64'(bus.m_val[0]), 64'h13);
    consume();

    // deg=0 with junk above
    p = rand_poly(); p[0] = 8'h55;
    t = rand_pts();
    send(p, 0, t, 4'hF);
    expect_result("t4", p, 0, t, 4'hF);
    check_eq("t4_lit", 64'(bus.m_val[2]), 64'h55);
    consume();

    p = rand_poly(); t = rand_pts();
    send(p, MAX_DEG + 3, t, 4'hF);
    expect_result("clamp", p, MAX_DEG + 3, t, 4'hF);
    consume();

    p = rand_poly(); t = rand_pts();
    send(p, 3, t, 4'b1011);
    expect_result("ignore_hi", p, 3, t, 4'b1011);
    consume();

    p = '0; t = rand_pts();
    send(p, 5, t, 4'b0111);
    expect_result("zero_poly", p, 5, t, 4'b0111);
    check_eq("zero_poly_lit", 64'(bus.m_zero), 64'h7);
    consume();

    // backpressure, then same-cycle release and accept
    p = rand_poly(); t = rand_pts();
    send(p, 4, t, 4'hF);
    expect_result("bp1", p, 4, t, 4'hF);
    snap = bus.m_val; zsnap = bus.m_zero;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      if (!bus.m_vld || bus.m_val !== snap || bus.m_zero !== zsnap || bus.s_rdy !== 1'b0)
        stable = 1'b0;
    end
    check_eq("bp_stable", 64'(stable), 64'(1));
    p2 = rand_poly(); t2 = rand_pts();
    bus.s_poly = p2; bus.s_deg = DEG_W'(3); bus.s_pts = t2; bus.s_mask = 4'b1101;
    bus.s_vld = 1'b1; bus.m_rdy = 1'b1;
    #1;
    check_eq("bp_s_rdy", 64'(bus.s_rdy), 64'(1));
    @(posedge aclk); #1;
    bus.s_vld = 1'b0; bus.m_rdy = 1'b0;
    expect_result("bp2", p2, 3, t2, 4'b1101);
    consume();

    // reset during EVAL
    p = rand_poly(); t = rand_pts();
    send(p, 8, t, 4'hF);
    @(posedge aclk); #1;
    #1 areset = 1'b1;
    #1;
    check_eq("mid_rst_m_vld", 64'(bus.m_vld), 64'(0));
    check_eq("mid_rst_m_val", 64'(bus.m_val), 64'(0));
    check_eq("mid_rst_m_zero", 64'(bus.m_zero), 64'(0));
    check_eq("mid_rst_m_mask", 64'(bus.m_mask), 64'(0));
    @(posedge aclk); #3 areset = 1'b0;
    saw_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge aclk); #1;
      if (bus.m_vld) saw_vld = 1'b1;
    end
    check_eq("post_rst_no_vld", 64'(saw_vld), 64'(0));
    check_eq("post_rst_s_rdy", 64'(bus.s_rdy), 64'(1));
    p = rand_poly(); t = rand_pts();
    send(p, 6, t, 4'hF);
    expect_result("post_rst", p, 6, t, 4'hF);
    consume();

    for (int k = 0; k < 40; k++) begin
      p = rand_poly(); t = rand_pts();
      deg = $urandom_range(0, MAX_DEG + 4);
      send(p, deg, t, 4'($urandom));
      expect_result("rnd", p, deg, t, bus.s_mask);
      stall = $urandom_range(0, 3);
      snap = bus.m_val;
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge aclk); #1;
        if (!bus.m_vld || bus.m_val !== snap) stable = 1'b0;
      end
      check_eq("rnd_stall", 64'(stable), 64'(1));
      consume();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
